// File: rtl/escribir_status_rtc_if.sv
// rtl/escribir_status_rtc_if.sv - multiplexed address/data bus between the status writer and the RTC
interface escribir_status_rtc_if;
    logic [7:0] AD_in;
    logic [7:0] AD_out;
    logic       ad_oe;
    logic       A_D;
    logic       CS_n;
    logic       WR_n;
    logic       RD_n;

    modport master (
        input  AD_in,
        output AD_out, ad_oe, A_D, CS_n, WR_n, RD_n
    );

    modport slave (
        output AD_in,
        input  AD_out, ad_oe, A_D, CS_n, WR_n, RD_n
    );
endinterface

// File: rtl/escribir_status_rtc.sv
// rtl/escribir_status_rtc.sv - writes Mod_s to the RTC FH/CRONO register over a two-phase muxed bus
// Optional readback verification is enabled by defining ESCRIBIR_READBACK_EN.
module escribir_status_rtc #(
    parameter logic [7:0] ADDR_FH    = 8'h00,
    parameter logic [7:0] ADDR_CRONO = 8'h01,
    parameter int         T_SETUP    = 1,
    parameter int         T_PULSE    = 4,
    parameter int         T_GAP      = 2
) (
    input  logic                  reloj,
    input  logic                  resetM,
    input  logic [7:0]            Mod_s,
    input  logic                  enable_status_fh,
    input  logic                  enable_status_crono,
    escribir_status_rtc_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  verify_err
);

    localparam int T_MAX = (T_SETUP > T_PULSE) ? ((T_SETUP > T_GAP) ? T_SETUP : T_GAP)
                                               : ((T_PULSE > T_GAP) ? T_PULSE : T_GAP);
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_SETUP, S_ADDR_WR, S_GAP, S_DATA_SETUP, S_DATA_WR, S_HOLD, S_DONE,
        S_RB_GAP1, S_RB_ADDR_SETUP, S_RB_ADDR_WR, S_RB_GAP2, S_RB_RD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    addr_q;
    logic [7:0]    data_q;
    logic          en_fh_q;
    logic          en_crono_q;
    logic          p_fh;
    logic          p_crono;

    logic rise_fh;
    logic rise_crono;
    logic acc_fh;
    logic acc_crono;

    assign rise_fh    = enable_status_fh & ~en_fh_q;
    assign rise_crono = enable_status_crono & ~en_crono_q;
    assign acc_fh     = (state == S_IDLE) & p_fh;
    assign acc_crono  = (state == S_IDLE) & ~p_fh & p_crono;

    // Phase length of each state, loaded into the down-counter on entry.
    function automatic logic [CW-1:0] load_for(input state_t s);
        case (s)
            S_ADDR_SETUP, S_DATA_SETUP, S_RB_ADDR_SETUP: load_for = CW'(T_SETUP - 1);
            S_ADDR_WR, S_DATA_WR, S_RB_ADDR_WR, S_RB_RD: load_for = CW'(T_PULSE - 1);
            S_GAP, S_RB_GAP1, S_RB_GAP2:                 load_for = CW'(T_GAP - 1);
            default:                                     load_for = '0;
        endcase
    endfunction

    function automatic state_t next_of(input state_t s);
        case (s)
            S_ADDR_SETUP:    next_of = S_ADDR_WR;
            S_ADDR_WR:       next_of = S_GAP;
            S_GAP:           next_of = S_DATA_SETUP;
            S_DATA_SETUP:    next_of = S_DATA_WR;
            S_DATA_WR:       next_of = S_HOLD;
`ifdef ESCRIBIR_READBACK_EN
            S_HOLD:          next_of = S_RB_GAP1;
`else
            S_HOLD:          next_of = S_DONE;
`endif
            S_RB_GAP1:       next_of = S_RB_ADDR_SETUP;
            S_RB_ADDR_SETUP: next_of = S_RB_ADDR_WR;
            S_RB_ADDR_WR:    next_of = S_RB_GAP2;
            S_RB_GAP2:       next_of = S_RB_RD;
            S_RB_RD:         next_of = S_DONE;
            default:         next_of = S_IDLE;
        endcase
    endfunction

`ifndef ESCRIBIR_READBACK_EN
    logic unused_ad_in;
    assign unused_ad_in = ^bus.AD_in;
`endif

    // Request capture, arbitration, phase sequencing and registered bus outputs.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            state       <= S_IDLE;
            cnt         <= '0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            en_fh_q     <= 1'b0;
            en_crono_q  <= 1'b0;
            p_fh        <= 1'b0;
            p_crono     <= 1'b0;
            bus.AD_out  <= 8'h00;
            bus.ad_oe   <= 1'b0;
            bus.A_D     <= 1'b0;
            bus.CS_n    <= 1'b1;
            bus.WR_n    <= 1'b1;
            bus.RD_n    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            verify_err  <= 1'b0;
        end else begin
            en_fh_q    <= enable_status_fh;
            en_crono_q <= enable_status_crono;
            // A fresh edge in the acceptance cycle wins over the clear.
            p_fh       <= (p_fh & ~acc_fh) | rise_fh;
            p_crono    <= (p_crono & ~acc_crono) | rise_crono;

            // Bus pins follow the current state one cycle later, all from flops.
            case (state)
                S_ADDR_SETUP, S_ADDR_WR, S_RB_ADDR_SETUP, S_RB_ADDR_WR: begin
                    bus.AD_out <= addr_q;
                    bus.ad_oe  <= 1'b1;
                    bus.A_D    <= 1'b0;
                    bus.CS_n   <= 1'b0;
                    bus.WR_n   <= ~((state == S_ADDR_WR) || (state == S_RB_ADDR_WR));
                    bus.RD_n   <= 1'b1;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                end
                S_GAP, S_RB_GAP1, S_RB_GAP2: begin
                    bus.ad_oe  <= 1'b0;
                    bus.CS_n   <= 1'b1;
                    bus.WR_n   <= 1'b1;
                    bus.RD_n   <= 1'b1;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                end
                S_DATA_SETUP, S_DATA_WR, S_HOLD: begin
                    bus.AD_out <= data_q;
                    bus.ad_oe  <= 1'b1;
                    bus.A_D    <= 1'b1;
                    bus.CS_n   <= 1'b0;
                    bus.WR_n   <= ~(state == S_DATA_WR);
                    bus.RD_n   <= 1'b1;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                end
`ifdef ESCRIBIR_READBACK_EN
                S_RB_RD: begin
                    bus.ad_oe  <= 1'b0;
                    bus.A_D    <= 1'b1;
                    bus.CS_n   <= 1'b0;
                    bus.WR_n   <= 1'b1;
                    bus.RD_n   <= 1'b0;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                end
`endif
                S_DONE: begin
                    bus.AD_out <= 8'h00;
                    bus.ad_oe  <= 1'b0;
                    bus.A_D    <= 1'b0;
                    bus.CS_n   <= 1'b1;
                    bus.WR_n   <= 1'b1;
                    bus.RD_n   <= 1'b1;
                    busy       <= 1'b1;
                    done       <= 1'b1;
                end
                default: begin
                    bus.AD_out <= 8'h00;
                    bus.ad_oe  <= 1'b0;
                    bus.A_D    <= 1'b0;
                    bus.CS_n   <= 1'b1;
                    bus.WR_n   <= 1'b1;
                    bus.RD_n   <= 1'b1;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase

            case (state)
                S_IDLE: begin
                    if (acc_fh || acc_crono) begin
                        addr_q     <= acc_fh ? ADDR_FH : ADDR_CRONO;
                        data_q     <= Mod_s;
                        verify_err <= 1'b0;
                        state      <= S_ADDR_SETUP;
                        cnt        <= load_for(S_ADDR_SETUP);
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= next_of(state);
                        cnt   <= load_for(next_of(state));
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
`ifdef ESCRIBIR_READBACK_EN
                    // This edge closes the last visible RD_n-low cycle.
                    if (state == S_DONE) begin
                        verify_err <= (bus.AD_in != data_q);
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_escribir_status_rtc.sv
// tb/tb_escribir_status_rtc.sv - directed and randomized checks of escribir_status_rtc
module tb_escribir_status_rtc;
    localparam int TS = 1;
    localparam int TP = 4;
    localparam int TG = 2;
`ifdef ESCRIBIR_READBACK_EN
    localparam int RB_EXTRA = 2*TG + TS + 2*TP;
    localparam int NWR      = 3;
    localparam int NRD      = 1;
    localparam bit RB       = 1'b1;
`else
    localparam int RB_EXTRA = 0;
    localparam int NWR      = 2;
    localparam int NRD      = 0;
    localparam bit RB       = 1'b0;
`endif
    localparam int LAT = 2*TS + 2*TP + TG + 2 + RB_EXTRA;
    localparam logic [7:0] A_FH = 8'h00;
    localparam logic [7:0] A_CR = 8'h01;

    typedef struct { logic a_d; logic [7:0] ad; int len; } ph_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } exp_t;

    logic       reloj = 1'b0;
    logic       resetM = 1'b1;
    logic [7:0] Mod_s = 8'h00;
    logic       en_fh = 1'b0;
    logic       en_cr = 1'b0;
    logic       busy, done, verify_err;

    int total = 0;
    int bad = 0;

    escribir_status_rtc_if bus_if();

    escribir_status_rtc #(
        .ADDR_FH(A_FH), .ADDR_CRONO(A_CR), .T_SETUP(TS), .T_PULSE(TP), .T_GAP(TG)
    ) dut (
        .reloj(reloj),
        .resetM(resetM),
        .Mod_s(Mod_s),
        .enable_status_fh(en_fh),
        .enable_status_crono(en_cr),
        .bus(bus_if),
        .busy(busy),
        .done(done),
        .verify_err(verify_err)
    );

    always #5 reloj = ~reloj;

    // Bus monitor: records each strobe-low run and flags any pin moving under a strobe.
    ph_t wr_q[$];
    int  rd_q[$];
    int  glitch_cnt = 0;
    int  wr_run = 0;
    int  rd_run = 0;
    logic [7:0] wr_ad;
    logic       wr_a_d;

    always @(negedge reloj) begin
        if (resetM) begin
            wr_run = 0;
            rd_run = 0;
        end else begin
            if (bus_if.WR_n === 1'b0) begin
                if (wr_run == 0) begin
                    wr_ad  = bus_if.AD_out;
                    wr_a_d = bus_if.A_D;
                end
                wr_run++;
                if (bus_if.AD_out !== wr_ad || bus_if.A_D !== wr_a_d || bus_if.CS_n !== 1'b0 ||
                    bus_if.ad_oe !== 1'b1 || bus_if.RD_n !== 1'b1)
                    glitch_cnt++;
            end else if (wr_run != 0) begin
                wr_q.push_back('{a_d: wr_a_d, ad: wr_ad, len: wr_run});
                wr_run = 0;
            end
            if (bus_if.RD_n === 1'b0) begin
                rd_run++;
                if (bus_if.CS_n !== 1'b0 || bus_if.ad_oe !== 1'b0 || bus_if.A_D !== 1'b1 ||
                    bus_if.WR_n !== 1'b1)
                    glitch_cnt++;
            end else if (rd_run != 0) begin
                rd_q.push_back(rd_run);
                rd_run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge reloj);
    endtask

    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        do begin
            tick();
            cyc++;
        end while (done !== 1'b1 && cyc < start + 200);
    endtask

    // Called on the negedge where done is seen; checks the finished write end to end.
    task automatic check_txn(input string tag, input logic [7:0] addr, input logic [7:0] data,
                             input logic exp_verr);
        ph_t p;
        chk({tag, "_verify_err"}, verify_err, exp_verr);
        tick();
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_n_wr"}, wr_q.size(), NWR);
        if (wr_q.size() >= NWR) begin
            p = wr_q.pop_front();
            chk({tag, "_addr_ph"}, {p.a_d, p.ad}, {1'b0, addr});
            chk({tag, "_addr_len"}, p.len, TP);
            p = wr_q.pop_front();
            chk({tag, "_data_ph"}, {p.a_d, p.ad}, {1'b1, data});
            chk({tag, "_data_len"}, p.len, TP);
            if (RB) begin
                p = wr_q.pop_front();
                chk({tag, "_rb_addr_ph"}, {p.a_d, p.ad, p.len}, {1'b0, addr, TP});
            end
        end
        chk({tag, "_n_rd"}, rd_q.size(), NRD);
        if (rd_q.size() > 0) chk({tag, "_rd_len"}, rd_q[0], TP);
        wr_q.delete();
        rd_q.delete();
    endtask

    initial begin
        int         cyc;
        int         n;
        int         kind;
        logic [7:0] m;
        logic [7:0] rbv;
        exp_t       e;
        exp_t       eq[$];
        logic [15:0] idle_vec;

        idle_vec = {8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset held with requests active: nothing may start.
        Mod_s = 8'hA5;
        en_fh = 1'b1;
        en_cr = 1'b1;
        bus_if.AD_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("reset_outputs", {bus_if.AD_out, bus_if.ad_oe, bus_if.A_D, bus_if.CS_n, bus_if.WR_n,
                                  bus_if.RD_n, busy, done, verify_err}, idle_vec);
        end
        en_fh = 1'b0;
        en_cr = 1'b0;
        tick();
        resetM = 1'b0;
        repeat (5) tick();
        chk("post_reset_idle", {bus_if.AD_out, bus_if.ad_oe, bus_if.A_D, bus_if.CS_n, bus_if.WR_n,
                                bus_if.RD_n, busy, done, verify_err}, idle_vec);

        // Single FH write.
        Mod_s = 8'h3C;
        bus_if.AD_in = 8'h3C;
        en_fh = 1'b1;
        tick();
        en_fh = 1'b0;
        wait_done(1, cyc);
        chk("fh_latency", cyc, LAT + 2);
        check_txn("fh", A_FH, 8'h3C, 1'b0);
        tick();

        // Simultaneous requests; a second CRONO edge while pending is absorbed.
        Mod_s = 8'h11;
        bus_if.AD_in = 8'h11;
        en_fh = 1'b1;
        en_cr = 1'b1;
        repeat (5) tick();
        en_cr = 1'b0;
        tick();
        en_cr = 1'b1;
        wait_done(6, cyc);
        chk("both_first_latency", cyc, LAT + 2);
        check_txn("both_fh", A_FH, 8'h11, 1'b0);
        wait_done(0, cyc);
        chk("both_second_latency", cyc, LAT);
        check_txn("both_crono", A_CR, 8'h11, 1'b0);
        en_fh = 1'b0;
        en_cr = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) n++;
        end
        chk("absorbed_extra_done", n, 0);

        // Mod_s changes during the address strobe; data must be the captured value.
        Mod_s = 8'h55;
        bus_if.AD_in = 8'h55;
        en_fh = 1'b1;
        tick();
        en_fh = 1'b0;
        cyc = 1;
        while (!(bus_if.WR_n === 1'b0 && bus_if.A_D === 1'b0) && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("capture_addr_wr_seen", cyc < 60, 1'b1);
        Mod_s = 8'hFF;
        wait_done(cyc, cyc);
        chk("capture_latency", cyc, LAT + 2);
        check_txn("capture", A_FH, 8'h55, 1'b0);
        tick();

`ifdef ESCRIBIR_READBACK_EN
        // Readback mismatch sets verify_err; it clears on the next acceptance.
        Mod_s = 8'h77;
        bus_if.AD_in = 8'h76;
        en_fh = 1'b1;
        tick();
        en_fh = 1'b0;
        wait_done(1, cyc);
        chk("rb_latency", cyc, LAT + 2);
        check_txn("rb_mismatch", A_FH, 8'h77, 1'b1);
        Mod_s = 8'h12;
        bus_if.AD_in = 8'h12;
        en_cr = 1'b1;
        tick();
        chk("rb_err_held", verify_err, 1'b1);
        en_cr = 1'b0;
        tick();
        chk("rb_err_cleared", verify_err, 1'b0);
        wait_done(2, cyc);
        chk("rb_next_latency", cyc, LAT + 2);
        check_txn("rb_match", A_CR, 8'h12, 1'b0);
        tick();
`endif

        // Randomized requests against a transaction-level model.
        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(0, 2);
            m    = 8'($urandom);
            rbv  = ($urandom_range(0, 1) == 1) ? (m ^ 8'(1 << $urandom_range(0, 7))) : m;
            Mod_s = m;
            bus_if.AD_in = rbv;
            if (kind != 1) eq.push_back('{addr: A_FH, data: m});
            if (kind != 0) eq.push_back('{addr: A_CR, data: m});
            en_fh = (kind != 1);
            en_cr = (kind != 0);
            wait_done(0, cyc);
            chk("rand_first_latency", cyc, LAT + 2);
            e = eq.pop_front();
            check_txn("rand", e.addr, e.data, RB && (rbv != m));
            while (eq.size() > 0) begin
                wait_done(0, cyc);
                chk("rand_next_latency", cyc, LAT);
                e = eq.pop_front();
                check_txn("rand_next", e.addr, e.data, RB && (rbv != m));
            end
            en_fh = 1'b0;
            en_cr = 1'b0;
            chk("rand_idle_busy", busy, 1'b0);
            repeat ($urandom_range(1, 3)) tick();
        end

        // Reset during the data strobe: bus idles at once, no done afterwards.
        Mod_s = 8'h5A;
        bus_if.AD_in = 8'h5A;
        en_fh = 1'b1;
        tick();
        en_fh = 1'b0;
        cyc = 1;
        while (!(bus_if.WR_n === 1'b0 && bus_if.A_D === 1'b1) && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("midop_data_wr_seen", cyc < 60, 1'b1);
        resetM = 1'b1;
        #1;
        chk("midop_bus_idle", {bus_if.CS_n, bus_if.WR_n, busy, done}, 4'b1100);
        tick();
        tick();
        wr_q.delete();
        rd_q.delete();
        resetM = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        chk("midop_no_done", n, 0);
        chk("midop_no_strobes", wr_q.size() + rd_q.size(), 0);

        chk("strobe_glitches", glitch_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
